fetch_decode_unit: RTL and testbench



---
 rtl/c0_isa_pkg.sv | 50 +++++
 rtl/isa_decoder.sv | 47 ++++
 rtl/fetch_decode_unit.sv | 126 ++++++++++++
 tb/tb_fetch_decode_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/c0_isa_pkg.sv
// rtl/c0_isa_pkg.sv - C0 instruction-set encodings, field offsets and fetch FSM states
package c0_isa_pkg;

  localparam logic [1:0] ITYPE_JMP  = 2'b00;
  localparam logic [1:0] ITYPE_MOV  = 2'b01;
  localparam logic [1:0] ITYPE_CMP  = 2'b10;
  localparam logic [1:0] ITYPE_MATH = 2'b11;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  // Word layout, MSB first: type[1:0], irs, op, tgt, asel, imm
  function automatic int ins_width(input int op_w, input int rsel_w, input int imm_w);
    return 3 + op_w + 2 * rsel_w + imm_w;
  endfunction

  function automatic int asel_lsb(input int imm_w);
    return imm_w;
  endfunction

  function automatic int tgt_lsb(input int rsel_w, input int imm_w);
    return imm_w + rsel_w;
  endfunction

  function automatic int op_lsb(input int rsel_w, input int imm_w);
    return imm_w + 2 * rsel_w;
  endfunction

  function automatic int irs_bit(input int op_w, input int rsel_w, input int imm_w);
    return imm_w + 2 * rsel_w + op_w;
  endfunction

  function automatic int type_lsb(input int op_w, input int rsel_w, input int imm_w);
    return imm_w + 2 * rsel_w + op_w + 1;
  endfunction

endpackage

// File: rtl/isa_decoder.sv
// rtl/isa_decoder.sv - purely combinational C0 instruction field decoder
import c0_isa_pkg::*;

module isa_decoder #(
  parameter int OP_W   = 4,
  parameter int RSEL_W = 3,
  parameter int IMM_W  = 8,
  localparam int INS_W = ins_width(OP_W, RSEL_W, IMM_W)
) (
  input  logic [INS_W-1:0]  ir,
  output logic              alu,
  output logic              mem,
  output logic              jmp,
  output logic [1:0]        ms,
  output logic              irs,
  output logic [OP_W-1:0]   op,
  output logic [RSEL_W-1:0] tgt,
  output logic [RSEL_W-1:0] asel,
  output logic [RSEL_W-1:0] bsel,
  output logic [IMM_W-1:0]  imm
);

  localparam int TYPE_LSB = type_lsb(OP_W, RSEL_W, IMM_W);
  localparam int IRS_BIT  = irs_bit(OP_W, RSEL_W, IMM_W);
  localparam int OP_LSB   = op_lsb(RSEL_W, IMM_W);
  localparam int TGT_LSB  = tgt_lsb(RSEL_W, IMM_W);
  localparam int ASEL_LSB = asel_lsb(IMM_W);

  logic [1:0] itype;

  assign itype = ir[TYPE_LSB +: 2];
  assign irs   = ir[IRS_BIT];
  assign op    = ir[OP_LSB +: OP_W];
  assign tgt   = ir[TGT_LSB +: RSEL_W];
  assign asel  = ir[ASEL_LSB +: RSEL_W];
  assign imm   = ir[IMM_W-1:0];
  // B select shares the top of the immediate field
  assign bsel  = imm[IMM_W-RSEL_W +: RSEL_W];

  assign alu = itype[1];
  assign mem = itype[0];
  assign jmp = (itype == ITYPE_JMP);

  assign ms[1] = (itype[1] ^ irs) & ~(&itype);
  assign ms[0] = (itype[0] ^ irs) & ~(&itype);

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC, boot, instruction fetch and registered decode; FETCH_HALT_ON_ZERO_EN adds halt-on-zero-word
import c0_isa_pkg::*;

module fetch_decode_unit #(
  parameter int               ADDR_W    = 8,
  parameter int               OP_W      = 4,
  parameter int               RSEL_W    = 3,
  parameter int               IMM_W     = 8,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  localparam int              INS_W     = ins_width(OP_W, RSEL_W, IMM_W)
) (
  input  logic              CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [INS_W-1:0]  mem_rdata,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              dec_alu,
  output logic              dec_mem,
  output logic              dec_jmp,
  output logic [1:0]        dec_ms,
  output logic              dec_irs,
  output logic [OP_W-1:0]   dec_op,
  output logic [RSEL_W-1:0] dec_tgt,
  output logic [RSEL_W-1:0] dec_asel,
  output logic [RSEL_W-1:0] dec_bsel,
  output logic [IMM_W-1:0]  dec_imm,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              halted
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ir_pc;
  logic [INS_W-1:0]  ir;
  logic              ir_zero;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign ir_zero = (ir == '0);
  assign halted  = (state == S_HALT) & ~reset;
`else
  assign ir_zero = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_BOOT;
      pc    <= BOOT_ADDR;
      ir_pc <= BOOT_ADDR;
      ir    <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          // A redirect wins over a same-cycle ack; that data belongs to the old stream
          if (br_valid) begin
            pc <= br_target;
          end else if (mem_ack) begin
            ir    <= mem_rdata;
            ir_pc <= pc;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (dec_ready && ir_zero) begin
            state <= S_HALT;
          end else if (br_valid) begin
            pc    <= br_target;
            state <= S_REQ;
          end else if (dec_ready) begin
            pc    <= pc + 1'b1;
            state <= S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  logic              raw_alu, raw_mem, raw_jmp, raw_irs;
  logic [1:0]        raw_ms;
  logic [OP_W-1:0]   raw_op;
  logic [RSEL_W-1:0] raw_tgt, raw_asel, raw_bsel;
  logic [IMM_W-1:0]  raw_imm;

  isa_decoder #(
    .OP_W   (OP_W),
    .RSEL_W (RSEL_W),
    .IMM_W  (IMM_W)
  ) u_decoder (
    .ir   (ir),
    .alu  (raw_alu),
    .mem  (raw_mem),
    .jmp  (raw_jmp),
    .ms   (raw_ms),
    .irs  (raw_irs),
    .op   (raw_op),
    .tgt  (raw_tgt),
    .asel (raw_asel),
    .bsel (raw_bsel),
    .imm  (raw_imm)
  );

  assign mem_req   = (state == S_REQ) & ~reset;
  assign mem_addr  = reset ? BOOT_ADDR : pc;
  assign dec_valid = (state == S_HOLD) & ~reset;
  assign dec_pc    = reset ? BOOT_ADDR : ir_pc;

  // Fields read as zero unless presented, so the all-zero word never shows JMP while idle
  assign dec_alu  = dec_valid & raw_alu;
  assign dec_mem  = dec_valid & raw_mem;
  assign dec_jmp  = dec_valid & raw_jmp;
  assign dec_irs  = dec_valid & raw_irs;
  assign dec_ms   = {2{dec_valid}} & raw_ms;
  assign dec_op   = {OP_W{dec_valid}} & raw_op;
  assign dec_tgt  = {RSEL_W{dec_valid}} & raw_tgt;
  assign dec_asel = {RSEL_W{dec_valid}} & raw_asel;
  assign dec_bsel = {RSEL_W{dec_valid}} & raw_bsel;
  assign dec_imm  = {IMM_W{dec_valid}} & raw_imm;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - randomized bench for fetch_decode_unit against a transaction-level model
module tb_fetch_decode_unit;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [20:0] mem_rdata;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        dec_valid;
  logic        dec_ready;
  logic        dec_alu, dec_mem, dec_jmp, dec_irs;
  logic [1:0]  dec_ms;
  logic [3:0]  dec_op;
  logic [2:0]  dec_tgt, dec_asel, dec_bsel;
  logic [7:0]  dec_imm;
  logic [7:0]  dec_pc;
  logic        halted;

  always #5 CLK = ~CLK;

  fetch_decode_unit dut (
    .CLK       (CLK),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .br_valid  (br_valid),
    .br_target (br_target),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_alu   (dec_alu),
    .dec_mem   (dec_mem),
    .dec_jmp   (dec_jmp),
    .dec_ms    (dec_ms),
    .dec_irs   (dec_irs),
    .dec_op    (dec_op),
    .dec_tgt   (dec_tgt),
    .dec_asel  (dec_asel),
    .dec_bsel  (dec_bsel),
    .dec_imm   (dec_imm),
    .dec_pc    (dec_pc),
    .halted    (halted)
  );

  logic [20:0] image [256];
  int n_checks = 0;
  int n_pass   = 0;

  // Model: booting / waiting for fetch of m_pc / holding word from m_ipc / halted
  bit       m_boot, m_have, m_halt;
  logic [7:0] m_pc, m_ipc;
  int issued = 0;
  int observed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_fields(input logic [20:0] w);
    int t, irs, op, tgt, asel, imm, bsel, ms;
    t    = int'(w >> 19) & 3;
    irs  = int'(w >> 18) & 1;
    op   = int'(w >> 14) & 15;
    tgt  = int'(w >> 11) & 7;
    asel = int'(w >> 8) & 7;
    imm  = int'(w) & 255;
    bsel = imm / 32;
    case (t * 2 + irs)
      0: ms = 0;  1: ms = 3;  2: ms = 1;  3: ms = 2;
      4: ms = 2;  5: ms = 1;  default: ms = 0;
    endcase
    return 32'((t / 2) * (1 << 26) + (t % 2) * (1 << 25) + ((t == 0) ? (1 << 24) : 0)
             + ms * (1 << 22) + irs * (1 << 21) + op * (1 << 17) + tgt * (1 << 14)
             + asel * (1 << 11) + bsel * (1 << 8) + imm);
  endfunction

  function automatic logic [31:0] got_fields();
    return {5'd0, dec_alu, dec_mem, dec_jmp, dec_ms, dec_irs, dec_op,
            dec_tgt, dec_asel, dec_bsel, dec_imm};
  endfunction

  // Called at posedge+1: check outputs against the model, drive this cycle's inputs, advance.
  task automatic step(input bit ack, input bit rdy, input bit br, input logic [7:0] tgt);
    if (m_halt) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_req", 32'(mem_req), 32'd0);
      chk("halt_valid", 32'(dec_valid), 32'd0);
    end else begin
      chk("halted_low", 32'(halted), 32'd0);
      if (m_boot) begin
        chk("boot_req", 32'(mem_req), 32'd0);
        chk("boot_valid", 32'(dec_valid), 32'd0);
      end else if (m_have) begin
        chk("hold_valid", 32'(dec_valid), 32'd1);
        chk("hold_req", 32'(mem_req), 32'd0);
        chk("dec_pc", 32'(dec_pc), 32'(m_ipc));
        chk("fields", got_fields(), exp_fields(image[m_ipc]));
      end else begin
        chk("req", 32'(mem_req), 32'd1);
        chk("req_valid", 32'(dec_valid), 32'd0);
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      end
    end
    mem_ack   = ack;
    mem_rdata = image[mem_addr];
    dec_ready = rdy;
    br_valid  = br;
    br_target = tgt;
    if (dec_valid && rdy) observed++;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      if (!m_have) begin
        if (br) m_pc = tgt;
        else if (ack) begin m_have = 1'b1; m_ipc = m_pc; end
      end else if (rdy && HALT_EN && image[m_ipc] == 21'd0) begin
        m_halt = 1'b1; m_have = 1'b0; issued++;
      end else if (br || rdy) begin
        if (rdy) issued++;
        m_pc   = br ? tgt : m_ipc + 8'd1;
        m_have = 1'b0;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; dec_ready = 1'b0; br_valid = 1'b0;
    br_target = 8'd0; mem_rdata = 21'd0;
    @(posedge CLK); #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fields", got_fields(), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'd0);
    reset  = 1'b0;
    m_boot = 1'b1; m_have = 1'b0; m_halt = 1'b0; m_pc = 8'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      image[i] = 21'($urandom);
      if (image[i] == 21'd0) image[i] = 21'd1;
    end
    image[0] = 21'h0C0005;
    image[1] = 21'h180020;
    image[3] = 21'h000000;

    do_reset();
    step(1, 1, 0, 8'd0);
    step(1, 1, 0, 8'd0);
    chk("mov_ms", 32'(dec_ms), 32'd2);
    chk("mov_tgt", 32'(dec_tgt), 32'd0);
    chk("mov_imm", 32'(dec_imm), 32'd5);
    chk("mov_pc", 32'(dec_pc), 32'd0);
    step(0, 1, 0, 8'd0);
    chk("next_addr", 32'(mem_addr), 32'd1);

    step(0, 1, 0, 8'd0);
    step(0, 1, 0, 8'd0);
    step(1, 1, 0, 8'd0);
    chk("add_alu", 32'(dec_alu), 32'd1);
    chk("add_ms", 32'(dec_ms), 32'd0);
    chk("add_asel", 32'(dec_asel), 32'd0);
    chk("add_bsel", 32'(dec_bsel), 32'd1);

    step(0, 1, 0, 8'd0);
    step(1, 0, 0, 8'd0);
    repeat (5) step(1, 0, 0, 8'd0);
    chk("stall_pc", 32'(dec_pc), 32'd2);

    step(0, 0, 1, 8'h40);
    chk("flush_valid", 32'(dec_valid), 32'd0);
    chk("flush_addr", 32'(mem_addr), 32'h40);
    step(1, 0, 0, 8'd0);
    chk("br_dec_pc", 32'(dec_pc), 32'h40);
    step(0, 1, 1, 8'h40);
    chk("br_issue_addr", 32'(mem_addr), 32'h40);

    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd0);
    step(1, 0, 1, 8'hFF);
    chk("br_ack_drop", 32'(dec_valid), 32'd0);
    chk("br_req_addr", 32'(mem_addr), 32'hFF);
    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd0);
    chk("wrap_addr", 32'(mem_addr), 32'h00);

    step(0, 0, 1, 8'd3);
    step(1, 0, 0, 8'd0);
    chk("zero_jmp", 32'(dec_jmp), 32'd1);
    step(0, 1, 0, 8'd0);
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt_set", 32'(halted), 32'd1);
    repeat (4) step(1, 1, 1, 8'h10);
`else
    chk("zero_next", 32'(mem_addr), 32'd4);
`endif
    image[3] = 21'h0A5A5A;
    do_reset();

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)));
    do_reset();
    chk("issue_count", 32'(observed), 32'(issued));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
